// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct encodings, boot ROM image, hex segment table and
// memory map constants shared by the cpu core and its register file.
package cpu_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int DMEM_DEPTH = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [31:0] TUBE_ADDR = 32'h0000_0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Sums 10+9+...+1 into $8 and stores it to the tube register, then spins.
    localparam logic [31:0] ROM_PROGRAM [IMEM_DEPTH] = '{
        0:       32'h2008_0000,  // addi $8,$0,0
        1:       32'h2009_000A,  // addi $9,$0,10
        2:       32'h1120_0003,  // beq  $9,$0,+3
        3:       32'h0109_4021,  // addu $8,$8,$9
        4:       32'h2129_FFFF,  // addi $9,$9,-1
        5:       32'h0800_0002,  // j    0x08
        6:       32'hAC08_0100,  // sw   $8,0x100($0)
        7:       32'h0800_0007,  // j    0x1C
        default: 32'h0000_0000
    };

    // Active-high {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/cpu_if.sv
// cpu_if: register file access bus; the core is master, the register file slave.
interface cpu_if;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
    modport slave  (input ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile: 32x32 registers, two combinational read ports, one write
// port on the clock edge. $0 reads as zero and ignores writes.
module cpu_regfile
    import cpu_pkg::*;
(
    input logic  sysclk,
    input logic  reset,
    cpu_if.slave rf
);
    logic [31:0] regs [NUM_REGS];

    // Synchronous clear on reset, otherwise a single write per cycle
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rf.we && rf.wa != 5'd0) begin
            regs[rf.wa] <= rf.wd;
        end
    end

    assign rf.rd1 = (rf.ra1 == 5'd0) ? 32'h0 : regs[rf.ra1];
    assign rf.rd2 = (rf.ra2 == 5'd0) ? 32'h0 : regs[rf.ra2];
endmodule

// File: rtl/cpu.sv
// cpu: single-cycle MIPS32 subset (addu/subu/and/or/slt/addi/beq/j/lw/sw)
// with a 32-word ROM, 32-word data RAM, a tube data register at 0x100 and a
// scanned 4-digit hex display of its low 16 bits.
// Build macro LEADING_ZERO_BLANK_EN: blank digits above the most significant
// nonzero digit (digit 0 is always shown).
module cpu
    import cpu_pkg::*;
#(
    parameter int SCAN_CYCLES = 1000
) (
    input  logic       sysclk,
    input  logic       reset,
    output logic [3:0] tube_select,
    output logic [7:0] tube_segment
);
    localparam logic [19:0] SCAN_LAST = 20'(SCAN_CYCLES - 1);

    cpu_if rf_bus ();

    logic [31:0] pc, pc_next, pc_plus4, instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] imm_sext, rs_val, rt_val, mem_addr, load_data;
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] tube_data;
    logic        dmem_hit, tube_hit, dmem_we, tube_we;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [19:0] scan_cnt;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_nib;
    logic [7:0]  seg_next;
    logic        unused_bits;

    cpu_regfile u_regfile (
        .sysclk (sysclk),
        .reset  (reset),
        .rf     (rf_bus)
    );

    // Fetch and decode; anything beyond the ROM reads as a nop
    assign instr    = (pc[31:7] == '0) ? ROM_PROGRAM[pc[6:2]] : 32'h0;
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign jidx     = instr[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign pc_plus4 = pc + 32'd4;

    assign rf_bus.ra1 = rs;
    assign rf_bus.ra2 = rt;
    assign rf_bus.we  = rf_we;
    assign rf_bus.wa  = rf_wa;
    assign rf_bus.wd  = rf_wd;
    assign rs_val     = rf_bus.rd1;
    assign rt_val     = rf_bus.rd2;

    // Word-addressed data space: byte offset bits are ignored
    assign mem_addr    = rs_val + imm_sext;
    assign dmem_hit    = (mem_addr[31:7] == '0);
    assign tube_hit    = (mem_addr[31:2] == TUBE_ADDR[31:2]);
    assign load_data   = dmem_hit ? dmem[mem_addr[6:2]] :
                         tube_hit ? tube_data : 32'h0;
    assign unused_bits = ^{mem_addr[1:0], instr[10:6]};

    // Execute: next PC, register write-back and store enables
    always_comb begin
        pc_next = pc_plus4;
        rf_we   = 1'b0;
        rf_wa   = rd;
        rf_wd   = 32'h0;
        dmem_we = 1'b0;
        tube_we = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rf_wa = rd;
                case (funct)
                    FN_ADDU: begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
                    FN_SUBU: begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
                    FN_AND:  begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
                    FN_OR:   begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
                    FN_SLT:  begin
                        rf_we = 1'b1;
                        rf_wd = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val + imm_sext; end
            OP_LW:   begin rf_we = 1'b1; rf_wa = rt; rf_wd = load_data; end
            OP_SW:   begin dmem_we = dmem_hit; tube_we = tube_hit; end
            OP_BEQ:  if (rs_val == rt_val) pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
            OP_J:    pc_next = {pc_plus4[31:28], jidx, 2'b00};
            default: ;
        endcase
    end

    // PC, data RAM and tube register
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            pc        <= 32'h0;
            tube_data <= 32'h0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            pc <= pc_next;
            if (dmem_we) dmem[mem_addr[6:2]] <= rt_val;
            if (tube_we) tube_data <= rt_val;
        end
    end

    // Segment pattern for the digit currently selected
    always_comb begin
        digit_nib = tube_data[{digit_idx, 2'b00} +: 4];
        seg_next  = seg_encode(digit_nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_idx != 2'd0 && (tube_data[15:0] >> {digit_idx, 2'b00}) == 16'h0)
            seg_next = 8'h00;
`endif
    end

    // Scan timer and registered display outputs
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            scan_cnt     <= '0;
            digit_idx    <= 2'd0;
            tube_select  <= 4'b0001;
            tube_segment <= 8'h3F;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 20'd1;
            end
            tube_select  <= 4'b0001 << digit_idx;
            tube_segment <= seg_next;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: scoreboard bench for the cpu. Expected tube-register writes and
// display digits are queued by the stimulus process and consumed by
// independent monitors when the DUT produces them.
`timescale 1ns/1ps
module tb_cpu;
    localparam int SCAN = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] EXP_SEG_HI = 8'h00;
`else
    localparam logic [7:0] EXP_SEG_HI = 8'h3F;
`endif

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       rf_reset = 1'b0;
    logic [3:0] tube_select;
    logic [7:0] tube_segment;

    int checks = 0;
    int errors = 0;
    int rel_cyc = 0;

    cpu #(.SCAN_CYCLES(SCAN)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .tube_select  (tube_select),
        .tube_segment (tube_segment)
    );

    cpu_if rf_bus ();
    cpu_regfile u_rf_unit (
        .sysclk (sysclk),
        .reset  (rf_reset),
        .rf     (rf_bus)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (!reset) rel_cyc <= 0;
        else        rel_cyc <= rel_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Tube-register write scoreboard
    typedef struct { logic [31:0] value; int cyc; } tube_exp_t;
    tube_exp_t   tube_q[$];
    tube_exp_t   tube_e;
    logic [31:0] tube_prev;
    logic        mon_en = 1'b0;

    always @(negedge sysclk) begin
        if (mon_en && dut.tube_data !== tube_prev) begin
            if (tube_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tube_unexpected: value %h at cycle %0d", dut.tube_data, rel_cyc);
            end else begin
                tube_e = tube_q.pop_front();
                check("tube_value", dut.tube_data, tube_e.value);
                check("tube_cycle", rel_cyc, tube_e.cyc);
            end
            tube_prev = dut.tube_data;
        end
    end

    // Display scoreboard: one entry per digit change once aligned on digit 0
    typedef struct { logic [3:0] sel; logic [7:0] seg; } disp_exp_t;
    disp_exp_t  disp_q[$];
    disp_exp_t  disp_e;
    logic       disp_arm = 1'b0;
    logic       disp_run = 1'b0;
    logic       disp_first = 1'b1;
    int         hold_cnt = 0;
    logic [3:0] sel_prev = 4'b0;

    always @(negedge sysclk) begin
        if (disp_arm) begin
            if (tube_select !== sel_prev) begin
                if (!disp_run && tube_select == 4'b0001) disp_run = 1'b1;
                if (disp_run && disp_q.size() > 0) begin
                    disp_e = disp_q.pop_front();
                    check("disp_select", tube_select, disp_e.sel);
                    check("disp_segment", tube_segment, disp_e.seg);
                    if (!disp_first) check("disp_hold", hold_cnt, SCAN);
                    disp_first = 1'b0;
                end
                hold_cnt = 1;
            end else begin
                hold_cnt++;
            end
        end
        sel_prev = tube_select;
    end

    task automatic wait_tube_empty(input string name, input int budget);
        int n = 0;
        while (tube_q.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        if (tube_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d writes pending", name, tube_q.size());
            tube_q.delete();
        end
    endtask

    task automatic wait_disp_empty(input int budget);
        int n = 0;
        while (disp_q.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        if (disp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL disp_timeout: %0d digits pending", disp_q.size());
            disp_q.delete();
        end
    endtask

    // Instructions injected at the fetch port once the program is spinning
    typedef struct { logic [31:0] word; int rsel; logic [31:0] val; } force_t;
    localparam int NFORCE = 11;
    force_t ftab [NFORCE] = '{
        '{32'hAC08_0000,  8, 32'h0000_0037},  // sw   $8,0($0)
        '{32'h8C0A_0000, 10, 32'h0000_0037},  // lw   $10,0($0)
        '{32'h8C0B_0100, 11, 32'h0000_0037},  // lw   $11,0x100($0)
        '{32'h8C0A_0200, 10, 32'h0000_0000},  // lw   $10,0x200($0) unmapped
        '{32'h0008_6823, 13, 32'hFFFF_FFC9},  // subu $13,$0,$8
        '{32'h01A0_702A, 14, 32'h0000_0001},  // slt  $14,$13,$0
        '{32'h01A8_7824, 15, 32'h0000_0001},  // and  $15,$13,$8
        '{32'h01A8_8025, 16, 32'hFFFF_FFFF},  // or   $16,$13,$8
        '{32'h2000_0005,  0, 32'h0000_0000},  // addi $0,$0,5
        '{32'hFC08_0001,  8, 32'h0000_0037},  // unsupported opcode
        '{32'h0109_403F,  8, 32'h0000_0037}   // unsupported funct
    };
    logic [31:0] force_word;
    logic [31:0] pc_before;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rf_bus.we  = 1'b0;
        rf_bus.wa  = 5'd0;
        rf_bus.wd  = 32'h0;
        rf_bus.ra1 = 5'd0;
        rf_bus.ra2 = 5'd0;

        // Reset held for two edges
        reset = 1'b0;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check("rst_select", tube_select, 32'h1);
        check("rst_segment", tube_segment, 32'h3F);
        check("rst_pc", dut.pc, 32'h0);
        tube_prev = dut.tube_data;
        mon_en = 1'b1;

        // Program run: 0x37 lands on the 44th edge after release
        tube_q.push_back('{32'h37, 44});
        reset = 1'b1;
        wait_tube_empty("run1", 100);
        check("reg8", dut.u_regfile.regs[8], 32'd55);
        check("reg9", dut.u_regfile.regs[9], 32'd0);
        repeat (20) @(negedge sysclk);
        check("tube_hold", dut.tube_data, 32'h37);
        check("spin_pc", dut.pc, 32'h1C);

        // Display scan of 0x0037, two full rounds
        for (int r = 0; r < 2; r++) begin
            disp_q.push_back('{4'b0001, 8'h07});
            disp_q.push_back('{4'b0010, 8'h4F});
            disp_q.push_back('{4'b0100, EXP_SEG_HI});
            disp_q.push_back('{4'b1000, EXP_SEG_HI});
        end
        disp_first = 1'b1;
        disp_run   = 1'b0;
        disp_arm   = 1'b1;
        wait_disp_empty(100);
        disp_arm = 1'b0;

        // Reset after completion clears the tube register
        tube_q.push_back('{32'h0, 0});
        reset = 1'b0;
        @(negedge sysclk);
        wait_tube_empty("clear", 5);
        reset = 1'b1;

        // Reset pulse mid-program at cycle 20
        for (int n = 0; n < 40 && rel_cyc < 20; n++) @(negedge sysclk);
        check("mid_cycle", rel_cyc, 32'd20);
        check("mid_reg8_busy", (dut.u_regfile.regs[8] != 0), 32'h1);
        reset = 1'b0;
        @(negedge sysclk);
        check("mid_pc", dut.pc, 32'h0);
        check("mid_reg8", dut.u_regfile.regs[8], 32'h0);
        check("mid_reg9", dut.u_regfile.regs[9], 32'h0);
        check("mid_dmem0", dut.dmem[0], 32'h0);
        check("mid_scan", dut.scan_cnt, 32'h0);
        check("mid_digit", dut.digit_idx, 32'h0);
        check("mid_select", tube_select, 32'h1);
        check("mid_segment", tube_segment, 32'h3F);
        tube_q.push_back('{32'h37, 44});
        reset = 1'b1;
        wait_tube_empty("run2", 100);

        // Injected instructions: result register and PC+4
        for (int i = 0; i < NFORCE; i++) begin
            pc_before  = dut.pc;
            force_word = ftab[i].word;
            force dut.instr = force_word;
            @(negedge sysclk);
            release dut.instr;
            check($sformatf("inj%0d_reg", i), dut.u_regfile.regs[ftab[i].rsel], ftab[i].val);
            check($sformatf("inj%0d_pc", i), dut.pc, pc_before + 32'd4);
        end
        check("inj_dmem0", dut.dmem[0], 32'h37);

        // Stand-alone register file through the interface
        rf_reset = 1'b0;
        @(negedge sysclk);
        rf_reset   = 1'b1;
        rf_bus.we  = 1'b1;
        rf_bus.wa  = 5'd5;
        rf_bus.wd  = 32'hDEAD_BEEF;
        @(negedge sysclk);
        rf_bus.wa  = 5'd0;
        rf_bus.wd  = 32'h1234_5678;
        @(negedge sysclk);
        rf_bus.we  = 1'b0;
        rf_bus.ra1 = 5'd5;
        rf_bus.ra2 = 5'd0;
        #1;
        check("rf_read5", rf_bus.rd1, 32'hDEAD_BEEF);
        check("rf_read0", rf_bus.rd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
